// File: rtl/tap_master.sv
// JTAG TAP master: runs TAP-reset, IR/DR scan and idle-clock commands on a divided TCK,
// capturing TDO during the shift bits and returning it through a valid/ready response.
module tap_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [6:0]  cmd_len_i,
    input  logic [63:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    input  logic        tdo_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StShift,
        StPost,
        StResp
    } state_e;

    localparam logic [1:0] OpReset = 2'b00;
    localparam logic [1:0] OpIr    = 2'b01;
    localparam logic [1:0] OpDr    = 2'b10;
    localparam logic [1:0] OpIdle  = 2'b11;

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
    localparam logic [6:0] MaxLen  = 7'(MAX_LEN);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [6:0]  len_q, len_d;
    logic [63:0] data_q, data_d;
    logic [63:0] rsp_q, rsp_d;
    logic [7:0]  div_q, div_d;
    logic        half_q, half_d;
    logic [6:0]  bit_q, bit_d;
    logic        tms_q, tms_d;

    logic        zero_len;
    logic [6:0]  pre_len, shift_len, post_len, cur_len;
    logic        in_bit, bit_end, is_scan, tms_seq;
    state_e      next_phase;

    // Per-phase bit counts; a zero-length scan or idle skips every phase.
    always_comb begin
        zero_len  = (op_q != OpReset) && (len_q == 7'd0);
        is_scan   = (op_q == OpIr) || (op_q == OpDr);
        pre_len   = 7'd0;
        if (!zero_len) begin
            unique case (op_q)
                OpReset: pre_len = 7'd6;
                OpIr:    pre_len = 7'd4;
                OpDr:    pre_len = 7'd3;
                default: pre_len = 7'd0;
            endcase
        end
        shift_len = (op_q == OpReset) ? 7'd0 : len_q;
        post_len  = (is_scan && !zero_len) ? 7'd2 : 7'd0;

        cur_len    = 7'd0;
        next_phase = StResp;
        case (state_q)
            StPre: begin
                cur_len = pre_len;
                if (shift_len != 7'd0) begin
                    next_phase = StShift;
                end else if (post_len != 7'd0) begin
                    next_phase = StPost;
                end
            end
            StShift: begin
                cur_len = shift_len;
                if (post_len != 7'd0) begin
                    next_phase = StPost;
                end
            end
            StPost:  cur_len = post_len;
            default: cur_len = 7'd0;
        endcase

        in_bit  = (state_q == StPre || state_q == StShift || state_q == StPost) &&
                  (bit_q < cur_len);
        bit_end = in_bit && half_q && (div_q == DivLast);
    end

    always_comb begin
        tms_seq = 1'b0;
        case (state_q)
            StPre: begin
                case (op_q)
                    OpReset: tms_seq = (bit_q < 7'd5);
                    OpIr:    tms_seq = (bit_q < 7'd2);
                    OpDr:    tms_seq = (bit_q == 7'd0);
                    default: tms_seq = 1'b0;
                endcase
            end
            StShift: tms_seq = (op_q != OpIdle) && (bit_q == len_q - 7'd1);
            StPost:  tms_seq = (bit_q == 7'd0);
            default: tms_seq = 1'b0;
        endcase
    end

    // Pin values depend only on phase/bit registers, so they move exactly when a new
    // low phase begins. TMS keeps its last driven level while no bit is in progress.
    assign tck_o       = in_bit && half_q;
    assign tms_o       = in_bit ? tms_seq : tms_q;
    assign tdi_o       = (state_q == StShift) && (op_q != OpIdle) && in_bit &&
                         data_q[bit_q[5:0]];
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_data_o  = rsp_q;
    assign cmd_ready_o = (state_q == StIdle) && !rsp_valid_o;
    assign busy_o      = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        data_d  = data_q;
        rsp_d   = rsp_q;
        div_d   = div_q;
        half_d  = half_q;
        bit_d   = bit_q;
        tms_d   = tms_o;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    op_d    = cmd_op_i;
                    len_d   = (cmd_len_i > MaxLen) ? MaxLen : cmd_len_i;
                    data_d  = cmd_data_i;
                    rsp_d   = 64'd0;
                    div_d   = 8'd0;
                    half_d  = 1'b0;
                    bit_d   = 7'd0;
                    state_d = StPre;
                end
            end
            StPre, StShift, StPost: begin
                if (!in_bit) begin
                    state_d = next_phase;
                    div_d   = 8'd0;
                    half_d  = 1'b0;
                    bit_d   = 7'd0;
                end else begin
                    // TDO is taken in the cycle where TCK has just risen.
                    if (state_q == StShift && is_scan && half_q && div_q == 8'd0) begin
                        rsp_d[bit_q[5:0]] = tdo_i;
                    end
                    if (bit_end) begin
                        div_d  = 8'd0;
                        half_d = 1'b0;
                        if (bit_q + 7'd1 == cur_len) begin
                            bit_d   = 7'd0;
                            state_d = next_phase;
                        end else begin
                            bit_d = bit_q + 7'd1;
                        end
                    end else if (div_q == DivLast) begin
                        div_d  = 8'd0;
                        half_d = 1'b1;
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            op_q    <= 2'b00;
            len_q   <= 7'd0;
            data_q  <= 64'd0;
            rsp_q   <= 64'd0;
            div_q   <= 8'd0;
            half_q  <= 1'b0;
            bit_q   <= 7'd0;
            tms_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
            div_q   <= div_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            tms_q   <= tms_d;
        end
    end

endmodule

// File: tb/tb_tap_master.sv
// Directed bench for tap_master: TCK pulse/TMS/TDI recording plus a small JTAG target model
// (loopback or preloaded shift register shifted on falling TCK).
module tb_tap_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_len;
    logic [63:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        tck, tms, tdi, tdo;
    logic        busy;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    // Monitor / target state
    logic         mon_clr = 1'b0;
    int           pulse_cnt;
    int           last_rise;
    logic         period_bad;
    logic [127:0] tms_rec, tdi_rec;
    logic         sr_load = 1'b0;
    logic [63:0]  sr_init = 64'd0;
    logic [63:0]  sr;
    logic         loopback = 1'b0;
    int           win_lo = 1000;
    int           win_hi = 0;
    logic [63:0]  held;

    tap_master dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_len_i   (cmd_len),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .tck_o       (tck),
        .tms_o       (tms),
        .tdi_o       (tdi),
        .tdo_i       (tdo),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign tdo = loopback ? tdi : sr[0];

    always @(posedge tck or posedge mon_clr) begin
        if (mon_clr) begin
            pulse_cnt  = 0;
            last_rise  = 0;
            period_bad = 1'b0;
            tms_rec    = '0;
            tdi_rec    = '0;
        end else begin
            if (pulse_cnt < 128) begin
                tms_rec[pulse_cnt] = tms;
                tdi_rec[pulse_cnt] = tdi;
            end
            if (pulse_cnt > 0 && (cyc - last_rise) != 8) period_bad = 1'b1;
            last_rise = cyc;
            pulse_cnt = pulse_cnt + 1;
        end
    end

    always @(negedge tck or posedge sr_load) begin
        if (sr_load) sr = sr_init;
        else if (pulse_cnt >= win_lo && pulse_cnt <= win_hi) sr = sr >> 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [6:0] len, input logic [63:0] d);
        int n;
        @(negedge clk);
        mon_clr = 1'b1;
        #1 mon_clr = 1'b0;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = d;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("cmd_accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic ack_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = 7'd0;
        cmd_data  = 64'd0;
        rsp_ready = 1'b0;
        mon_clr   = 1'b1;
        #1 mon_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tck", {63'd0, tck}, 64'd0);
        check("rst_tms", {63'd0, tms}, 64'd1);
        check("rst_tdi", {63'd0, tdi}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {63'd0, cmd_ready}, 64'd1);

        // TAP reset command
        send_cmd(2'b00, 7'd0, 64'hFFFF);
        wait_rsp();
        check("reset_pulses", 64'(pulse_cnt), 64'd6);
        check("reset_tms", {58'd0, tms_rec[5:0]}, 64'h1F);
        check("reset_period", {63'd0, period_bad}, 64'd0);
        check("reset_data", rsp_data, 64'd0);
        check("reset_tck_resp", {63'd0, tck}, 64'd0);
        ack_rsp();

        // IR scan, loopback target
        loopback = 1'b1;
        send_cmd(2'b01, 7'd5, 64'h15);
        wait_rsp();
        check("ir_pulses", 64'(pulse_cnt), 64'd11);
        check("ir_tms", {53'd0, tms_rec[10:0]}, 64'h303);
        check("ir_tdi", {53'd0, tdi_rec[10:0]}, 64'h150);
        check("ir_period", {63'd0, period_bad}, 64'd0);
        check("ir_data", rsp_data, 64'h15);
        ack_rsp();

        // DR scan 64 bits, preloaded target
        loopback = 1'b0;
        win_lo   = 4;
        win_hi   = 67;
        sr_init  = 64'hA5A5A5A5_5A5A5A5A;
        sr_load  = 1'b1;
        #1 sr_load = 1'b0;
        send_cmd(2'b10, 7'd64, 64'hDEADBEEF_01234567);
        wait_rsp();
        check("dr64_pulses", 64'(pulse_cnt), 64'd69);
        check("dr64_tdi", tdi_rec[66:3], 64'hDEADBEEF_01234567);
        check("dr64_data", rsp_data, 64'hA5A5A5A5_5A5A5A5A);
        ack_rsp();

        // Length clamped to MAX_LEN
        sr_init = 64'h0F0F_1234_8765_F0F0;
        sr_load = 1'b1;
        #1 sr_load = 1'b0;
        send_cmd(2'b10, 7'd100, 64'd0);
        wait_rsp();
        check("dr100_pulses", 64'(pulse_cnt), 64'd69);
        check("dr100_data", rsp_data, 64'h0F0F_1234_8765_F0F0);
        ack_rsp();
        win_lo = 1000;

        // Zero-length scan: response two cycles after acceptance
        @(negedge clk);
        mon_clr = 1'b1;
        #1 mon_clr = 1'b0;
        cmd_op    = 2'b10;
        cmd_len   = 7'd0;
        cmd_data  = 64'hFF;
        cmd_valid = 1'b1;
        check("len0_ready", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("len0_valid_c1", {63'd0, rsp_valid}, 64'd0);
        check("len0_busy_c1", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check("len0_valid_c2", {63'd0, rsp_valid}, 64'd1);
        check("len0_data", rsp_data, 64'd0);
        check("len0_pulses", 64'(pulse_cnt), 64'd0);
        ack_rsp();

        // Idle clocks
        send_cmd(2'b11, 7'd3, 64'hFFFF_FFFF);
        wait_rsp();
        check("idle_pulses", 64'(pulse_cnt), 64'd3);
        check("idle_tms", {61'd0, tms_rec[2:0]}, 64'd0);
        check("idle_tdi", {61'd0, tdi_rec[2:0]}, 64'd0);
        check("idle_data", rsp_data, 64'd0);
        ack_rsp();

        // Response backpressure with a second command pending
        loopback = 1'b1;
        send_cmd(2'b01, 7'd8, 64'h3C);
        wait_rsp();
        held = 64'h3C;
        check("bp_data", rsp_data, held);
        cmd_op    = 2'b00;
        cmd_len   = 7'd0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_hold", rsp_data, held);
            check("bp_ready", {63'd0, cmd_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        mon_clr = 1'b1;
        #1 mon_clr = 1'b0;
        check("bp_idle_ready", {63'd0, cmd_ready}, 64'd1);
        check("bp_idle_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_accepted", {63'd0, busy}, 64'd1);
        wait_rsp();
        check("bp_second_pulses", 64'(pulse_cnt), 64'd6);
        ack_rsp();

        // Reset during the 10th shift bit of a DR scan
        send_cmd(2'b10, 7'd20, 64'hFFFFF);
        begin
            int n = 0;
            while (pulse_cnt < 13 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 2000) check("abort_wait_timeout", 64'd0, 64'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tck", {63'd0, tck}, 64'd0);
        check("abort_tms", {63'd0, tms}, 64'd1);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_valid", {63'd0, rsp_valid}, 64'd0);
        check("abort_ready", {63'd0, cmd_ready}, 64'd1);
        repeat (10) @(negedge clk);
        check("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
        send_cmd(2'b00, 7'd0, 64'd0);
        wait_rsp();
        check("abort_reset_pulses", 64'(pulse_cnt), 64'd6);
        check("abort_reset_tms", {58'd0, tms_rec[5:0]}, 64'h1F);
        check("abort_reset_data", rsp_data, 64'd0);
        ack_rsp();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tap_master.md
TAP_MASTER -- requirements
Module: tap_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, setting the length of each TCK half-period in clk_i cycles (legal range 1..255).
REQ-002 The block SHALL have parameter MAX_LEN, default 64, setting the maximum scan length in bits (legal range 1..64).
REQ-003 The block SHALL have these ports:
- clk_i in 1: the block's only clock.
- rst_i in 1: reset; one clock; synchronous, active-high.
- cmd_valid_i in 1: command offered.
- cmd_ready_o out 1: command accepted when high together with cmd_valid_i.
- cmd_op_i in 2: 00 TAP reset, 01 IR scan, 10 DR scan, 11 idle clocks.
- cmd_len_i in 7: bit count for scans, TCK count for idle.
- cmd_data_i in 64: TDI data, LSB shifted first.
- rsp_valid_o out 1: response available.
- rsp_ready_i in 1: response consumed when high together with rsp_valid_o.
- rsp_data_o out 64: captured TDO, bit i is the i-th shifted bit.
- tck_o out 1: JTAG clock.
- tms_o out 1: JTAG mode select.
- tdi_o out 1: JTAG data to target.
- tdo_i in 1: JTAG data from target.
- busy_o out 1: high while the FSM is not in IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, PRE, SHIFT, POST and RESP.
REQ-005 cmd_ready_o SHALL be high only when the FSM is in IDLE and rsp_valid_o is low.
REQ-006 On acceptance, the block SHALL latch op, data and effective length, then enter PRE on the next clk_i.
REQ-007 Effective length SHALL be min(cmd_len_i, MAX_LEN).
REQ-008 Each TCK bit SHALL last 2*CLK_DIV clk_i cycles: CLK_DIV cycles with tck_o=0, then CLK_DIV cycles with tck_o=1.
REQ-009 tms_o and tdi_o SHALL change only in the first clk_i cycle of a low phase.
REQ-010 tdo_i SHALL be sampled in the clk_i cycle in which tck_o goes from 0 to 1.
REQ-011 TAP reset (op 00) SHALL emit a TMS sequence of five 1s then one 0, ending in Run-Test/Idle; there is no SHIFT phase.
REQ-012 IR scan (op 01) SHALL emit:
- PRE: TMS 1,1,0,0.
- SHIFT: len bits with TMS=0 on all bits except the last, which has TMS=1.
- POST: TMS 1,0.
- Total: len+6 TCK pulses, starting and ending in Run-Test/Idle.
REQ-013 DR scan (op 10) SHALL emit:
- PRE: TMS 1,0,0.
- SHIFT: as for IR scan.
- POST: TMS 1,0.
- Total: len+5 TCK pulses.
REQ-014 Idle clocks (op 11) SHALL emit len TCK pulses with TMS=0 and TDI=0.
REQ-015 During SHIFT, tdi_o SHALL equal latched data bit i on shift bit i; outside SHIFT, tdi_o SHALL be 0.
REQ-016 The TDO value sampled on shift bit i SHALL be stored in bit i of rsp_data_o; bits len..63 SHALL be 0.
REQ-017 Ops 00 and 11 SHALL return rsp_data_o = 0.
REQ-018 An effective length of 0 for ops 01, 10 or 11 SHALL produce no TCK pulses; the FSM SHALL go directly to RESP with data 0.
REQ-019 The FSM SHALL enter RESP in the clk_i cycle after the final high phase ends, with tck_o=0 in that cycle.
REQ-020 In RESP, rsp_valid_o SHALL be 1.
REQ-021 rsp_valid_o and rsp_data_o SHALL be held stable until rsp_ready_i is sampled high; the FSM SHALL then return to IDLE on the next clk_i.
REQ-022 A command offered while rsp_valid_o=1 SHALL NOT be accepted; it stays pending with cmd_ready_o=0.
REQ-023 busy_o SHALL be 1 in PRE, SHIFT, POST and RESP.
REQ-024 The block SHALL NOT track the target's TAP state; after rst_i, a TAP reset command is required before scans give defined target behaviour.

Reset
REQ-025 While rst_i=1 at a clk_i edge, the block SHALL set: FSM=IDLE, tck_o=0, tms_o=1, tdi_o=0, rsp_valid_o=0, rsp_data_o=0, busy_o=0, and the divider and bit counters to 0.
REQ-026 rst_i asserted mid-command SHALL abort the command in the next cycle with no response.
REQ-027 After rst_i deasserts, cmd_ready_o SHALL be 1 from the first cycle.

Verification
REQ-028 Reset command, CLK_DIV=4 -> 6 TCK pulses of 8 clk_i cycles each, TMS 1,1,1,1,1,0; rsp_data_o=0.
REQ-029 IR scan, len=5, data=0x15, target loopback tdo=tdi -> 11 TCK pulses; TDI in SHIFT 1,0,1,0,1; TMS 1,1,0,0,0,0,0,0,1,1,0; rsp_data_o=0x15.
REQ-030 DR scan, len=64, data=0xDEADBEEF_01234567, target shift register preloaded with 0xA5A5A5A5_5A5A5A5A -> rsp_data_o=0xA5A5A5A5_5A5A5A5A; 69 TCK pulses.
REQ-031 DR scan with cmd_len_i=100 and MAX_LEN=64 -> exactly 69 TCK pulses; scan with len=0 -> no TCK pulses, rsp_valid_o=1 two cycles after acceptance.
REQ-032 rsp_ready_i held low for 20 cycles with a second command pending -> rsp_valid_o and rsp_data_o stable; cmd_ready_o=0; second command accepted one cycle after RESP exits.
REQ-033 rst_i pulsed during the 10th SHIFT bit -> next cycle tck_o=0, tms_o=1, busy_o=0, no response; a following reset command completes normally.
